// File: rtl/fll_cfg_responder.sv
// rtl/fll_cfg_responder.sv - FLL config-port responder: 4-entry regfile, emulated lock, divided clock-enable
// Optional feature macro: FLL_CFG_LOCK_IRQ_EN (lock_irq_o pulse and sticky lock-lost status bit 30).
module fll_cfg_responder #(
    parameter int unsigned ACK_LATENCY = 2,
    parameter int unsigned LOCK_CYCLES = 64,
    parameter logic [31:0] CFG1_RST    = 32'h0000_05F5,
    parameter logic [31:0] CFG2_RST    = 32'h0000_0000,
    parameter logic [31:0] CFG3_RST    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_req_i,
    input  logic        cfg_wrn_i,
    input  logic [1:0]  cfg_add_i,
    input  logic [31:0] cfg_wdata_i,
    output logic        cfg_ack_o,
    output logic [31:0] cfg_rdata_o,
    output logic        lock_o,
`ifdef FLL_CFG_LOCK_IRQ_EN
    output logic        lock_irq_o,
`endif
    output logic        clk_en_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_REL} state_e;

    localparam logic [3:0]  LAT_LOAD = 4'(ACK_LATENCY - 1);
    localparam logic [15:0] LOCK_MAX = 16'(LOCK_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [1:0]  add_q, add_d;
    logic        wrn_q, wrn_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cfg1_q, cfg1_d, cfg2_q, cfg2_d, cfg3_q, cfg3_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] lock_cnt_q, lock_cnt_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [3:0]  div_cur_q, div_cur_d;
    logic [15:0] div_mask;
    logic [31:0] rd_mux;
    logic        ack, wr_en, rd_en, cfg1_wr, locked, lost_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Requests are only sampled in IDLE; a req still held in REL is ignored.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        add_d   = add_q;
        wrn_d   = wrn_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: if (cfg_req_i) begin
                add_d   = cfg_add_i;
                wrn_d   = cfg_wrn_i;
                wdata_d = cfg_wdata_i;
                lat_d   = LAT_LOAD;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (lat_q == 4'd0) state_d = S_ACK;
                else               lat_d   = lat_q - 4'd1;
            end
            S_ACK:   state_d = S_REL;
            default: if (!cfg_req_i) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack         = (state_q == S_ACK);
        cfg_ack_o   = ack;
        rd_en       = ack && wrn_q;
        wr_en       = ack && !wrn_q;
        cfg_rdata_o = rd_en ? rd_mux : rdata_q;
        lock_o      = locked;
        clk_en_o    = locked && (div_cnt_q == 16'd0);
    end

    always_comb begin
        locked  = (lock_cnt_q == LOCK_MAX);
        cfg1_wr = wr_en && (add_q == 2'd1);
        case (add_q)
            2'd0:    rd_mux = {locked, lost_bit, 14'd0, lock_cnt_q};
            2'd1:    rd_mux = cfg1_q;
            2'd2:    rd_mux = cfg2_q;
            default: rd_mux = cfg3_q;
        endcase
        cfg1_d  = cfg1_wr ? wdata_q : cfg1_q;
        cfg2_d  = (wr_en && add_q == 2'd2) ? wdata_q : cfg2_q;
        cfg3_d  = (wr_en && add_q == 2'd3) ? wdata_q : cfg3_q;
        rdata_d = rd_en ? rd_mux : rdata_q;
        if (cfg1_wr)                    lock_cnt_d = 16'd0;
        else if (lock_cnt_q < LOCK_MAX) lock_cnt_d = lock_cnt_q + 16'd1;
        else                            lock_cnt_d = lock_cnt_q;
        // DIV is re-sampled only at period boundaries or while unlocked.
        div_mask  = (16'd1 << div_cur_q) - 16'd1;
        div_cnt_d = div_cnt_q;
        div_cur_d = div_cur_q;
        if (!locked || div_cnt_q == div_mask) begin
            div_cnt_d = 16'd0;
            div_cur_d = cfg1_q[29:26];
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q      <= 4'd0;
            add_q      <= 2'd0;
            wrn_q      <= 1'b0;
            wdata_q    <= 32'd0;
            cfg1_q     <= CFG1_RST;
            cfg2_q     <= CFG2_RST;
            cfg3_q     <= CFG3_RST;
            rdata_q    <= 32'd0;
            lock_cnt_q <= 16'd0;
            div_cnt_q  <= 16'd0;
            div_cur_q  <= 4'd0;
        end else begin
            lat_q      <= lat_d;
            add_q      <= add_d;
            wrn_q      <= wrn_d;
            wdata_q    <= wdata_d;
            cfg1_q     <= cfg1_d;
            cfg2_q     <= cfg2_d;
            cfg3_q     <= cfg3_d;
            rdata_q    <= rdata_d;
            lock_cnt_q <= lock_cnt_d;
            div_cnt_q  <= div_cnt_d;
            div_cur_q  <= div_cur_d;
        end
    end

`ifdef FLL_CFG_LOCK_IRQ_EN
    logic lock_prev_q, lock_prev_d, lost_q, lost_d;

    always_comb begin
        lock_prev_d = locked;
        lost_d      = lost_q;
        if (rd_en && add_q == 2'd0) lost_d = 1'b0;
        if (lock_prev_q && !locked) lost_d = 1'b1;
        lost_bit    = lost_q;
        lock_irq_o  = locked && !lock_prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_prev_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            lock_prev_q <= lock_prev_d;
            lost_q      <= lost_d;
        end
    end
`else
    assign lost_bit = 1'b0;
`endif

endmodule

// File: tb/tb_fll_cfg_responder.sv
// tb/tb_fll_cfg_responder.sv - scoreboard bench for fll_cfg_responder with a cycle-count reference model
module tb_fll_cfg_responder;

    localparam int LAT  = 2;
    localparam int LOCK = 64;
    localparam logic [31:0] C1_RST = 32'h0000_05F5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_req_i;
    logic        cfg_wrn_i;
    logic [1:0]  cfg_add_i;
    logic [31:0] cfg_wdata_i;
    logic        cfg_ack_o;
    logic [31:0] cfg_rdata_o;
    logic        lock_o;
    logic        clk_en_o;

    fll_cfg_responder #(
        .ACK_LATENCY(LAT),
        .LOCK_CYCLES(LOCK),
        .CFG1_RST(C1_RST),
        .CFG2_RST(32'h0),
        .CFG3_RST(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_req_i(cfg_req_i),
        .cfg_wrn_i(cfg_wrn_i),
        .cfg_add_i(cfg_add_i),
        .cfg_wdata_i(cfg_wdata_i),
        .cfg_ack_o(cfg_ack_o),
        .cfg_rdata_o(cfg_rdata_o),
        .lock_o(lock_o),
        .clk_en_o(clk_en_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        int          cyc;
    } txn_t;

    txn_t        sbq[$];
    logic [31:0] mcfg [4];
    logic [31:0] last_rd;
    int          c0;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mcfg[0] = 32'h0;
        mcfg[1] = C1_RST;
        mcfg[2] = 32'h0;
        mcfg[3] = 32'h0;
        last_rd = 32'h0;
        c0      = cyc;
    endtask

    // Monitor: lock/clk_en follow from cycles elapsed since the last lock restart.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            int  since;
            bit  exp_lock;
            bit  exp_en;
            int  div;
            since    = cyc - c0;
            exp_lock = (since >= LOCK);
            div      = int'(mcfg[1][29:26]);
            exp_en   = exp_lock && (((since - LOCK) % (1 << div)) == 0);
            chk("lock_o", {31'd0, lock_o}, {31'd0, exp_lock});
            chk("clk_en_o", {31'd0, clk_en_o}, {31'd0, exp_en});
            if (cfg_ack_o) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    txn_t t;
                    t = sbq.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(t.cyc));
                    if (t.rd) begin
                        chk("read_data", cfg_rdata_o, t.exp);
                        last_rd = t.exp;
                    end else begin
                        chk("rdata_hold_on_write", cfg_rdata_o, last_rd);
                        if (t.a == 2'd1) c0 = cyc + 1;
                        if (t.a != 2'd0) mcfg[t.a] = t.d;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit rd, input logic [1:0] a, input logic [31:0] d);
        txn_t t;
        int   lk;
        cfg_req_i   = 1'b1;
        cfg_wrn_i   = rd;
        cfg_add_i   = a;
        cfg_wdata_i = d;
        t.rd  = rd;
        t.a   = a;
        t.d   = d;
        t.cyc = cyc + LAT + 1;
        if (a == 2'd0) begin
            lk = t.cyc - c0;
            if (lk > LOCK) lk = LOCK;
            t.exp = 32'(lk);
            if (lk == LOCK) t.exp[31] = 1'b1;
        end else begin
            t.exp = mcfg[a];
        end
        sbq.push_back(t);
    endtask

    task automatic complete(input int hold);
        bit got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (cfg_ack_o) got = 1;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        repeat (hold) step();
        cfg_req_i = 1'b0;
        step();
    endtask

    task automatic xact(input bit rd, input logic [1:0] a, input logic [31:0] d, input int hold);
        issue(rd, a, d);
        complete(hold);
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_req_i   = 1'b0;
        cfg_wrn_i   = 1'b0;
        cfg_add_i   = 2'd0;
        cfg_wdata_i = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, cfg_ack_o}, 32'd0);
        chk("rst_rdata", cfg_rdata_o, 32'd0);
        chk("rst_lock", {31'd0, lock_o}, 32'd0);
        chk("rst_clk_en", {31'd0, clk_en_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        xact(1'b1, 2'd1, 32'd0, 0);
        repeat (70) step();
        xact(1'b1, 2'd0, 32'd0, 0);
        xact(1'b0, 2'd2, 32'h1234_5678, 0);
        xact(1'b1, 2'd2, 32'd0, 5);
        xact(1'b0, 2'd0, 32'hFFFF_FFFF, 0);
        xact(1'b1, 2'd0, 32'd0, 0);
        xact(1'b0, 2'd1, 32'h0C00_0100, 2);
        repeat (90) step();
        xact(1'b1, 2'd1, 32'd0, 0);

        for (int i = 0; i < 60; i++) begin
            int gap;
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(),
                 int'($urandom_range(0, 5)));
            gap = ($urandom_range(0, 7) == 0) ? 75 : int'($urandom_range(0, 3));
            repeat (gap) step();
        end

        xact(1'b0, 2'd1, 32'hFFFF_FFFF, 0);
        xact(1'b1, 2'd3, 32'd0, 0);
        issue(1'b1, 2'd1, 32'd0);
        step();
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("midrst_ack", {31'd0, cfg_ack_o}, 32'd0);
        chk("midrst_rdata", cfg_rdata_o, 32'd0);
        chk("midrst_lock", {31'd0, lock_o}, 32'd0);
        chk("midrst_clk_en", {31'd0, clk_en_o}, 32'd0);
        step();
        rst_n = 1'b1;
        model_reset();
        issue(1'b1, 2'd1, 32'd0);
        complete(0);
        repeat (80) step();
        xact(1'b1, 2'd0, 32'd0, 0);

        if (sbq.size() != 0) chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
